// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding fetches and buffers words in a small FIFO.
// Optional macro FETCH_PERF_CNT_EN adds FetchCount/DiscardCount performance counters.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemAck,
    input  logic [31:0]       ImemData,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              InstValid,
    input  logic              InstReady,
    output logic [31:0]       Instruction,
    output logic [5:0]        InstCode,
    output logic [ADDR_W-1:0] InstPC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       FetchCount,
    output logic [31:0]       DiscardCount
`endif
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] redir_pc;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, count_after_pop;
    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [31:0]       buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc [DEPTH];
    logic              ack, push, pop;

    assign redir_pc = {RedirectPC[ADDR_W-1:2], 2'b00};

    // Acks are only meaningful while a request is actually on the bus.
    always_comb begin
        ack             = ImemAck && req_q;
        push            = ack && (state_q == REQ) && !Redirect;
        pop             = InstReady && valid_q && !Redirect;
        count_after_pop = count_q - CNT_W'(pop);
        count_d         = count_after_pop + CNT_W'(push);
        wr_ptr_d        = wr_ptr_q + PTR_W'(push);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        inst_d          = inst_q;
        ipc_d           = ipc_q;
        if (count_after_pop != '0) begin
            inst_d = buf_data[rd_ptr_d];
            ipc_d  = buf_pc[rd_ptr_d];
        end else if (push) begin
            inst_d = ImemData;
            ipc_d  = addr_q;
        end
        if (Redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            inst_d   = inst_q;
            ipc_d    = ipc_q;
        end
        valid_d = (count_d != '0);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (count_q < DEPTH_C) state_d = REQ;
            end
            REQ: begin
                if (ack) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    state_d = (count_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (ack) begin
                    addr_d  = target_q;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        // An un-acked request must complete on the old address before the new target is used.
        if (Redirect) begin
            if (state_q == DISCARD) begin
                if (ack) begin
                    addr_d  = redir_pc;
                    state_d = REQ;
                end else begin
                    target_d = redir_pc;
                end
            end else if (req_q && !ack) begin
                addr_d   = addr_q;
                target_d = redir_pc;
                state_d  = DISCARD;
            end else begin
                addr_d  = redir_pc;
                state_d = REQ;
            end
        end
        req_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= REQ;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            inst_q   <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            buf_data[wr_ptr_q] <= ImemData;
            buf_pc[wr_ptr_q]   <= addr_q;
        end
    end

    assign ImemReq     = req_q;
    assign ImemAddr    = addr_q;
    assign InstValid   = valid_q;
    assign Instruction = inst_q;
    assign InstCode    = inst_q[31:26];
    assign InstPC      = ipc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] discard_cnt_q, discard_cnt_d;
    logic        dropped;

    always_comb begin
        dropped       = ack && (Redirect || (state_q == DISCARD));
        fetch_cnt_d   = fetch_cnt_q + 32'(push);
        discard_cnt_d = discard_cnt_q + 32'(dropped) + (Redirect ? 32'(count_q) : 32'd0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign FetchCount   = fetch_cnt_q;
    assign DiscardCount = discard_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: streaming, stall, redirects, reset mid-request, PC wrap.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
    logic [31:0] imem_addr, imem_data, redirect_pc, instruction, inst_pc;
    logic [5:0]  inst_code;

    logic        b_req, b_valid;
    logic [31:0] b_addr, b_data, b_inst, b_pc;
    logic [5:0]  b_code;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, discard_count, b_fetch_count, b_discard_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Both memory models return the word equal to its address.
    assign imem_data = imem_addr;
    assign b_data    = b_addr;

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .ImemReq(imem_req), .ImemAddr(imem_addr), .ImemAck(imem_ack), .ImemData(imem_data),
        .Redirect(redirect), .RedirectPC(redirect_pc),
        .InstValid(inst_valid), .InstReady(inst_ready),
        .Instruction(instruction), .InstCode(inst_code), .InstPC(inst_pc)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(fetch_count), .DiscardCount(discard_count)
`endif
    );

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .Clk(clk), .Rst_n(rst_n),
        .ImemReq(b_req), .ImemAddr(b_addr), .ImemAck(1'b1), .ImemData(b_data),
        .Redirect(1'b0), .RedirectPC(32'h0),
        .InstValid(b_valid), .InstReady(1'b1),
        .Instruction(b_inst), .InstCode(b_code), .InstPC(b_pc)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(b_fetch_count), .DiscardCount(b_discard_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        imem_ack    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", instruction, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_wrap_addr", b_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // Streaming: ack and ready every cycle.
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("a_req", imem_req, 1);
            chk("a_addr", imem_addr, 32'(4 * (k - 1)));
            if (k == 1) begin
                chk("a_valid0", inst_valid, 0);
                chk("w_addr0", b_addr, 32'hFFFF_FFFC);
            end else begin
                chk("a_valid", inst_valid, 1);
                chk("a_pc", inst_pc, 32'(4 * (k - 2)));
                chk("a_inst", instruction, 32'(4 * (k - 2)));
                chk("a_code", inst_code, 0);
            end
            if (k == 2) begin
                chk("w_pc0", b_pc, 32'hFFFF_FFFC);
                chk("w_code0", b_code, 6'h3F);
                chk("w_addr1", b_addr, 32'h0);
            end
            if (k == 3) begin
                chk("w_pc1", b_pc, 32'h0);
                chk("w_addr2", b_addr, 32'h4);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("a_fetch_cnt", fetch_count, 8);
`endif

        // Reset asserted mid-request at 0x20.
        chk("b_addr_pre", imem_addr, 32'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("b_req", imem_req, 0);
        chk("b_addr", imem_addr, 32'h0);
        chk("b_valid", inst_valid, 0);
        chk("b_inst", instruction, 0);
        chk("b_code", inst_code, 0);
        chk("b_pc", inst_pc, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("b_fetch_cnt", fetch_count, 0);
        chk("b_disc_cnt", discard_count, 0);
`endif
        inst_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Stall: ready low fills the buffer, then fetching stops.
        tick();
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 32'h0);
        tick();
        chk("c2_valid", inst_valid, 1);
        chk("c2_pc", inst_pc, 32'h0);
        chk("c2_addr", imem_addr, 32'h4);
        tick();
        chk("c3_req", imem_req, 0);
        chk("c3_pc", inst_pc, 32'h0);
        chk("c3_addr", imem_addr, 32'h8);
        tick();
        chk("c4_req", imem_req, 0);
        chk("c4_addr", imem_addr, 32'h8);
        chk("c4_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        chk("c5_valid", inst_valid, 1);
        chk("c5_pc", inst_pc, 32'h4);
        chk("c5_req", imem_req, 0);
        tick();
        chk("c6_valid", inst_valid, 0);
        chk("c6_req", imem_req, 1);
        chk("c6_addr", imem_addr, 32'h8);
        chk("c6_pc_hold", inst_pc, 32'h4);
        tick();
        chk("c7_valid", inst_valid, 1);
        chk("c7_pc", inst_pc, 32'h8);
        chk("c7_addr", imem_addr, 32'hC);

        // Redirect with same-cycle ack at 0x8 and pop, then redirect during a pending request.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("d3_pc", inst_pc, 32'h4);
        chk("d3_addr", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        tick();
        chk("d4_valid", inst_valid, 0);
        chk("d4_addr", imem_addr, 32'h10);
        chk("d4_req", imem_req, 1);
        chk("d4_pc_hold", inst_pc, 32'h4);
        redirect = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("d5_addr", imem_addr, 32'h10);
        chk("d5_req", imem_req, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        tick();
        chk("d6_addr", imem_addr, 32'h10);
        chk("d6_req", imem_req, 1);
        redirect    = 1'b0;
        redirect_pc = 32'h99;
        tick();
        chk("d7_addr", imem_addr, 32'h10);
        imem_ack = 1'b1;
        tick();
        chk("d8_addr", imem_addr, 32'h40);
        chk("d8_valid", inst_valid, 0);
        chk("d8_req", imem_req, 1);
        tick();
        chk("d9_valid", inst_valid, 1);
        chk("d9_pc", inst_pc, 32'h40);
        chk("d9_inst", instruction, 32'h40);
        chk("d9_addr", imem_addr, 32'h44);
`ifdef FETCH_PERF_CNT_EN
        chk("d9_fetch_cnt", fetch_count, 3);
        chk("d9_disc_cnt", discard_count, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
